// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: size codes, FSM states, lane geometry.
// Combinational only; no latency or flow control of its own.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPLIT,
        ST_RESP
    } state_t;

    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Load/store request and response bundle between the memory stage and dmem_ctrl.
// Request is valid/ready; the response is a one-cycle pulse with no backpressure.
interface dmem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane.sv
// One byte lane of data memory: DEPTH x 8, synchronous write and synchronous read.
// q_o holds the last read value and only updates when rden_i is high.
module dmem_lane #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [7:0]               data_i,
    input  logic                     wren_i,
    input  logic                     rden_i,
    output logic [7:0]               q_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] q_q;

    always_ff @(posedge clk_i) begin
        if (wren_i) mem_q[addr_i] <= data_i;
        if (rden_i) q_q <= mem_q[addr_i];
    end

    assign q_o = q_q;
endmodule

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory controller with sizing, extension and misaligned-access splitting.
// Aligned: response 1 cycle after accept, 1 req/cycle; split: 2 cycles, req_ready low in between.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic        m_clock,
    input  logic        p_reset,
    dmem_ctrl_if.slave  bus
);
    localparam int LANES  = lanes_of(DATA_W);
    localparam int OFF_W  = off_w_of(DATA_W);
    localparam int WIDX_W = $clog2(DEPTH);

    state_t state_q, state_d;

    logic [OFF_W-1:0]  off;
    logic [WIDX_W-1:0] widx;
    logic              req_err, req_split, acc;
    logic [LANES-1:0]  b0_mask, b1_mask;
    logic [DATA_W-1:0] wrot;

    logic              we_q, uns_q, err_q, split_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [WIDX_W-1:0] widx1_q;
    logic [DATA_W-1:0] wrot_q, hold_q;
    logic [LANES-1:0]  b1_mask_q;

    logic [WIDX_W-1:0] lane_addr;
    logic [DATA_W-1:0] lane_data, q_all;
    logic [LANES-1:0]  lane_wren;
    logic              lane_rden;

    logic [DATA_W-1:0] word0, shifted, ext;
    int                nbits;
    logic              addr_unused;

    assign off       = bus.req_addr[OFF_W-1:0];
    assign widx      = bus.req_addr[OFF_W +: WIDX_W];
    assign req_err   = int'(bus.req_size) > OFF_W;
    assign req_split = !req_err && ((int'(off) + (1 << bus.req_size)) > LANES);
    assign bus.req_ready = !p_reset && (state_q != ST_SPLIT);
    assign acc       = bus.req_valid && bus.req_ready;
    // Only the word index takes part in addressing; the rest of the address aliases.
    assign addr_unused = ^bus.req_addr;

    always_comb begin
        b0_mask = '0;
        b1_mask = '0;
        wrot    = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l >= int'(off) && (l - int'(off)) < (1 << bus.req_size)) b0_mask[l] = 1'b1;
            if (req_split && l < (int'(off) + (1 << bus.req_size) - LANES)) b1_mask[l] = 1'b1;
            wrot[8*l +: 8] = bus.req_wdata[8*((l - int'(off) + LANES) % LANES) +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (acc) state_d = req_split ? ST_SPLIT : ST_RESP;
                else     state_d = ST_IDLE;
            end
            ST_SPLIT: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_err;
                split_q <= req_split;
                size_q  <= bus.req_size;
                off_q   <= off;
            end
        end
    end

    // Datapath registers need no reset: they are only consumed after a fresh accept.
    always_ff @(posedge m_clock) begin
        if (acc) begin
            widx1_q   <= widx + 1'b1;
            wrot_q    <= wrot;
            b1_mask_q <= b1_mask;
        end
        if (state_q == ST_SPLIT) hold_q <= q_all;
    end

    // Beat 1 is suppressed while reset is asserted so an aborted split writes only beat 0.
    always_comb begin
        if (state_q == ST_SPLIT) begin
            lane_addr = widx1_q;
            lane_data = wrot_q;
            lane_wren = (!p_reset && we_q) ? b1_mask_q : '0;
            lane_rden = !p_reset && !we_q;
        end else begin
            lane_addr = widx;
            lane_data = wrot;
            lane_wren = (acc && bus.req_we && !req_err) ? b0_mask : '0;
            lane_rden = acc && !bus.req_we && !req_err;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dmem_lane #(.DEPTH(DEPTH)) u_lane (
            .clk_i  (m_clock),
            .addr_i (lane_addr),
            .data_i (lane_data[8*g +: 8]),
            .wren_i (lane_wren[g]),
            .rden_i (lane_rden),
            .q_o    (q_all[8*g +: 8])
        );
    end

    always_comb begin
        nbits = DATA_W;
        case (size_q)
            SZ_B: nbits = 8;
            SZ_H: nbits = 16;
            SZ_W: nbits = 32;
            SZ_D: nbits = 64;
        endcase
        if (nbits > DATA_W) nbits = DATA_W;
        word0   = split_q ? hold_q : q_all;
        shifted = DATA_W'({q_all, word0} >> {off_q, 3'b000});
        ext     = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i < nbits) ? shifted[i] : (!uns_q && shifted[nbits-1]);
        end
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = bus.rsp_valid && err_q;
    assign bus.rsp_rdata = (bus.rsp_valid && !we_q && !err_q) ? ext : '0;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised and directed bench for dmem_ctrl against a flat byte-array memory model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int MEMB = 4096;

    logic m_clock = 1'b0;
    logic p_reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] mem_m [MEMB];

    dmem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_ctrl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32)) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    always #5 m_clock = ~m_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        logic [31:0] v;
        int n;
        v = '0;
        if (size == SZ_D) return v;
        n = 1 << size;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[(addr + i) % MEMB];
        if (!uns && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic int model_lat(input logic [31:0] addr, input logic [1:0] size);
        if (size == SZ_D) return 1;
        return ((addr % 4) + (1 << size) > 4) ? 2 : 1;
    endfunction

    // Drives one request from a negedge, returns at the negedge of its response cycle.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic mid_rdy);
        int w;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        lat = -1; rdata = 'x; err = 1'bx; mid_rdy = 1'bx;
        #1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge m_clock); #1; w++;
        end
        if (bus.req_ready) begin
            @(posedge m_clock); #1;
            bus.req_valid = 1'b0;
            if (we && size != SZ_D)
                for (int i = 0; i < (1 << size); i++) mem_m[(addr + i) % MEMB] = wdata[8*i +: 8];
            for (int c = 1; c <= 8; c++) begin
                @(negedge m_clock);
                if (c == 1) mid_rdy = bus.req_ready;
                if (bus.rsp_valid) begin
                    lat = c; rdata = bus.rsp_rdata; err = bus.rsp_err;
                    break;
                end
            end
        end else begin
            bus.req_valid = 1'b0;
            @(negedge m_clock);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_B;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        p_reset = 1'b1;
        repeat (3) @(posedge m_clock);
        @(negedge m_clock);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
        @(posedge m_clock); #1; p_reset = 1'b0;
        @(negedge m_clock);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_fill();
        int lat; logic [31:0] rd; logic er, mr;
        int nbad;
        nbad = 0;
        for (int w = 0; w < 1024; w++) begin
            send(1'b1, SZ_W, 1'b0, w * 4, $urandom(), lat, rd, er, mr);
            if (lat != 1) nbad++;
        end
        total++; if (nbad !== 0) begin bad++; $display("FAIL fill_latency got=%0d late exp=0", nbad); end
    endtask

    task automatic test_directed();
        int lat; logic [31:0] rd; logic er, mr;
        logic [31:0] bytes_e;
        send(1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, lat, rd, er, mr);
        send(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL word_load got=%h exp=11223344", rd); end
        total++; if (lat !== 1) begin bad++; $display("FAIL word_load_lat got=%0d exp=1", lat); end

        send(1'b1, SZ_B, 1'b0, 32'h11, 32'h80, lat, rd, er, mr);
        send(1'b0, SZ_B, 1'b0, 32'h11, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_signed got=%h exp=ffffff80", rd); end
        send(1'b0, SZ_B, 1'b1, 32'h11, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL byte_unsigned got=%h exp=00000080", rd); end
        send(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'h11228044) begin bad++; $display("FAIL word_after_byte got=%h exp=11228044", rd); end

        send(1'b1, SZ_W, 1'b0, 32'h0E, 32'hAABBCCDD, lat, rd, er, mr);
        total++; if (lat !== 2) begin bad++; $display("FAIL split_store_lat got=%0d exp=2", lat); end
        send(1'b0, SZ_W, 1'b0, 32'h0E, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'hAABBCCDD) begin bad++; $display("FAIL split_load got=%h exp=aabbccdd", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL split_load_lat got=%0d exp=2", lat); end
        total++; if (mr !== 1'b0) begin bad++; $display("FAIL split_mid_ready got=%b exp=0", mr); end
        bytes_e = 32'hAABBCCDD;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, SZ_B, 1'b1, 32'h0E + i, 32'h0, lat, rd, er, mr);
            total++;
            if (rd !== {24'h0, bytes_e[8*i +: 8]}) begin
                bad++; $display("FAIL split_byte%0d got=%h exp=%h", i, rd, bytes_e[8*i +: 8]);
            end
        end

        send(1'b1, SZ_H, 1'b0, 32'hFFF, 32'hBEEF, lat, rd, er, mr);
        send(1'b0, SZ_H, 1'b1, 32'hFFF, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL wrap_half got=%h exp=0000beef", rd); end
        send(1'b0, SZ_B, 1'b1, 32'h0, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'h000000BE) begin bad++; $display("FAIL wrap_byte0 got=%h exp=000000be", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [31:0] e [4];
        for (int k = 0; k < 4; k++) begin
            a[k] = {$urandom_range(0, 1023), 2'b00};
            e[k] = model_load(a[k], SZ_W, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%b exp=1", k-1, bus.rsp_valid); end
                total++; if (bus.rsp_rdata !== e[k-1]) begin bad++; $display("FAIL b2b_rdata%0d got=%h exp=%h", k-1, bus.rsp_rdata, e[k-1]); end
            end
            if (k < 4) begin
                total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", k, bus.req_ready); end
                bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_W;
                bus.req_unsigned = 1'b0; bus.req_addr = a[k];
            end else begin
                bus.req_valid = 1'b0;
            end
            @(negedge m_clock);
        end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL b2b_tail_rdata got=%h exp=0", bus.rsp_rdata); end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic er, mr;
        logic [31:0] e0, e1;
        e0 = model_load(32'h20, SZ_W, 1'b0);
        e1 = model_load(32'h24, SZ_W, 1'b0);
        send(1'b1, SZ_D, 1'b0, 32'h20, $urandom(), lat, rd, er, mr);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL illegal_store_err got=%b exp=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL illegal_store_rdata got=%h exp=0", rd); end
        total++; if (lat !== 1) begin bad++; $display("FAIL illegal_store_lat got=%0d exp=1", lat); end
        send(1'b0, SZ_D, 1'b0, 32'h21, 32'h0, lat, rd, er, mr);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL illegal_load got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        send(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, lat, rd, er, mr);
        total++; if (rd !== e0 || er !== 1'b0) begin bad++; $display("FAIL illegal_mem0 got=%h/%b exp=%h/0", rd, er, e0); end
        send(1'b0, SZ_W, 1'b0, 32'h24, 32'h0, lat, rd, er, mr);
        total++; if (rd !== e1) begin bad++; $display("FAIL illegal_mem1 got=%h exp=%h", rd, e1); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic er, mr;
        logic we, uns; logic [1:0] sz; logic [31:0] ad, wd, exp_rd;
        int exp_lat;
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? SZ_D : 2'($urandom_range(0, 2));
            ad  = $urandom();
            wd  = $urandom();
            exp_rd  = we ? 32'h0 : model_load(ad, sz, uns);
            exp_lat = model_lat(ad, sz);
            if ($urandom_range(0, 3) == 0) @(negedge m_clock);
            send(we, sz, uns, ad, wd, lat, rd, er, mr);
            total++;
            if (rd !== exp_rd || er !== (sz == SZ_D) || lat != exp_lat) begin
                bad++;
                $display("FAIL rand%0d we=%b sz=%0d addr=%h got rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                         n, we, sz, ad, rd, er, lat, exp_rd, (sz == SZ_D), exp_lat);
            end
        end
    endtask

    task automatic test_reset_split();
        int lat; logic [31:0] rd; logic er, mr;
        send(1'b1, SZ_W, 1'b0, 32'h0C, 32'h01020304, lat, rd, er, mr);
        send(1'b1, SZ_W, 1'b0, 32'h10, 32'h05060708, lat, rd, er, mr);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_W;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0E; bus.req_wdata = 32'hCAFEF00D;
        @(posedge m_clock); #1;
        bus.req_valid = 1'b0;
        p_reset = 1'b1;
        mem_m[14] = 8'h0D;
        mem_m[15] = 8'hF0;
        @(negedge m_clock);
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_rsp_mid got=%b exp=0", bus.rsp_valid); end
        @(posedge m_clock); #1;
        p_reset = 1'b0;
        @(negedge m_clock);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_rsp_after got=%b exp=0", bus.rsp_valid); end
        send(1'b0, SZ_W, 1'b0, 32'h0C, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'hF00D0304) begin bad++; $display("FAIL abort_beat0 got=%h exp=f00d0304", rd); end
        send(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, lat, rd, er, mr);
        total++; if (rd !== 32'h05060708) begin bad++; $display("FAIL abort_beat1 got=%h exp=05060708", rd); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_split();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
